// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-driven down-counting timer.
package tick_timer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tick_timer_if.sv
// Load handshake, tick/stop controls and status outputs of tick_timer.
interface tick_timer_if
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             tick;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic             stop;
  logic             expire;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output tick, load_valid, load_value, mode, stop,
    input  load_ready, expire, busy, count
  );

  modport slave (
    input  tick, load_valid, load_value, mode, stop,
    output load_ready, expire, busy, count
  );

endinterface

// File: rtl/tick_timer.sv
// Down-counting tick timer with one-shot and periodic (auto-reload) modes.
//
//   state | meaning
//   IDLE  | waiting for a load; load_ready=1, count held at 0 (or 0 from a zero load)
//   RUN   | counting ticks down to 1; expire on the terminal tick
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic         clk,
  input  logic         reset,
  tick_timer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          count_d  = bus.load_value;
          reload_d = bus.load_value;
          mode_d   = bus.mode;
          // a zero load never runs: it behaves as an immediate one-shot
          if (bus.load_value == '0) expire_d = 1'b1;
          else                      state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.tick) begin
          if (count_q == WIDTH'(1)) begin
            expire_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == RUN);
  assign bus.expire     = expire_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus randomized traffic vs a tick-count model.
module tb_tick_timer;
  import tick_timer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tick_timer_if #(.WIDTH(W)) bus ();
  tick_timer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Model: a loaded timer has counted m_n ticks of a period m_l; remaining = m_l - (m_n mod m_l).
  bit          m_run, m_per, m_exp;
  logic [W-1:0] m_l;
  int unsigned m_n;

  task automatic model_edge();
    m_exp = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_per = 1'b0; m_l = '0; m_n = 0;
    end else if (!m_run) begin
      if (bus.load_valid) begin
        m_l = bus.load_value; m_per = bus.mode; m_n = 0;
        if (bus.load_value == '0) m_exp = 1'b1;
        else                      m_run = 1'b1;
      end
    end else if (bus.stop) begin
      m_run = 1'b0;
    end else if (bus.tick) begin
      m_n++;
      if (m_n % 32'(m_l) == 0) begin
        m_exp = 1'b1;
        if (!m_per) m_run = 1'b0;
      end
    end
  endtask

  function automatic logic [W+2:0] exp_vec();
    logic [W-1:0] c;
    c = m_run ? W'(32'(m_l) - (m_n % 32'(m_l))) : '0;
    return {m_exp, m_run, !m_run, c};
  endfunction

  function automatic logic [W+2:0] dut_vec();
    return {bus.expire, bus.busy, bus.load_ready, bus.count};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.tick = 1'b0; bus.load_valid = 1'b0; bus.load_value = '0;
    bus.mode = MODE_ONESHOT; bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 3) reset = 1'b0;
      bus.tick = (k % 5 == 4);
      cycle();
      tests_run++;
      if (dut_vec() !== {3'b001, W'(0)}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), {3'b001, W'(0)});
      end
    end
  endtask

  task automatic test_oneshot();
    int ticks = 0;
    int seen  = 0;
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(3); bus.mode = MODE_ONESHOT;
    bus.tick = 1'b1;
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b010, W'(3)}) begin
      tests_failed++;
      $display("FAIL oneshot_accept got=%h exp=%h", dut_vec(), {3'b010, W'(3)});
    end
    idle_inputs();
    for (int k = 0; k < 40; k++) begin
      bus.tick = (k % 5 == 4);
      if (bus.tick && bus.busy) ticks++;
      cycle();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL oneshot_run cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.expire) begin
        seen++;
        tests_run++;
        if (ticks != 3) begin
          tests_failed++;
          $display("FAIL oneshot_expire_tick got=%0d exp=3", ticks);
        end
      end
    end
    tests_run++;
    if (seen != 1) begin
      tests_failed++;
      $display("FAIL oneshot_expire_count got=%0d exp=1", seen);
    end
    tests_run++;
    if (dut_vec() !== {3'b001, W'(0)}) begin
      tests_failed++;
      $display("FAIL oneshot_idle got=%h exp=%h", dut_vec(), {3'b001, W'(0)});
    end
  endtask

  task automatic test_periodic();
    int exps = 0;
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(2); bus.mode = MODE_PERIODIC;
    cycle();
    idle_inputs();
    for (int i = 0; i < 11; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        bus.tick = 1'b0;
        cycle();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL periodic_gap cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
        if (bus.expire) exps++;
      end
      bus.tick = (i < 10);
      cycle();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL periodic_tick cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.expire) exps++;
    end
    tests_run++;
    if (exps != 5 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL periodic_pulses got=%0d busy=%b exp=5 busy=1", exps, bus.busy);
    end
    bus.tick = 1'b0; bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic test_zero_load();
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = '0; bus.mode = 1'($urandom_range(0, 1));
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b101, W'(0)}) begin
      tests_failed++;
      $display("FAIL zero_load got=%h exp=%h", dut_vec(), {3'b101, W'(0)});
    end
    idle_inputs();
    bus.tick = 1'b1;
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b001, W'(0)}) begin
      tests_failed++;
      $display("FAIL zero_load_after got=%h exp=%h", dut_vec(), {3'b001, W'(0)});
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_stop_and_load_in_run();
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(1); bus.mode = MODE_PERIODIC;
    cycle();
    idle_inputs();
    bus.tick = 1'b1; bus.stop = 1'b1;
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b001, W'(0)}) begin
      tests_failed++;
      $display("FAIL stop_vs_terminal got=%h exp=%h", dut_vec(), {3'b001, W'(0)});
    end
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(5);
    cycle();
    bus.load_value = W'(9); bus.tick = 1'b1;
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b010, W'(4)}) begin
      tests_failed++;
      $display("FAIL load_in_run got=%h exp=%h", dut_vec(), {3'b010, W'(4)});
    end
    idle_inputs();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(4);
    cycle();
    idle_inputs();
    bus.tick = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests_run++;
    if (dut_vec() !== {3'b001, W'(0)}) begin
      tests_failed++;
      $display("FAIL reset_mid_run got=%h exp=%h", dut_vec(), {3'b001, W'(0)});
    end
    bus.tick = 1'b0; bus.load_valid = 1'b1; bus.load_value = W'(1);
    cycle();
    bus.load_valid = 1'b0; bus.tick = 1'b1;
    cycle();
    tests_run++;
    if (dut_vec() !== {3'b101, W'(0)}) begin
      tests_failed++;
      $display("FAIL reload_after_reset got=%h exp=%h", dut_vec(), {3'b101, W'(0)});
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_back_to_back();
    int loads = 0;
    idle_inputs();
    bus.load_valid = 1'b1; bus.load_value = W'(2);
    cycle();
    idle_inputs();
    for (int k = 0; k < 30 && loads < 3; k++) begin
      bus.tick = 1'b1;
      bus.load_valid = 1'b0;
      cycle();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.expire) begin
        loads++;
        bus.tick = 1'b0; bus.load_valid = 1'b1; bus.load_value = W'(loads + 2);
        cycle();
        tests_run++;
        if (dut_vec() !== {3'b010, W'(loads + 2)}) begin
          tests_failed++;
          $display("FAIL back_to_back_accept got=%h exp=%h", dut_vec(), {3'b010, W'(loads + 2)});
        end
      end
    end
    tests_run++;
    if (loads != 3) begin
      tests_failed++;
      $display("FAIL back_to_back_timeout got=%0d exp=3", loads);
    end
    idle_inputs();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int k = 0; k < 3000; k++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.tick       = 1'($urandom_range(0, 1));
      bus.stop       = ($urandom_range(0, 29) == 0);
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.mode       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       v = '1;
        1:       v = '1 - W'(1);
        default: v = W'($urandom_range(0, 6));
      endcase
      bus.load_value = v;
      cycle();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_load();
    test_stop_and_load_in_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
